// File: rtl/brancher_arbiter_if.sv
// Signal bundle between brancher_arbiter, its requesters and the shared brancher.
// master = arbiter view, slave = environment (requesters + brancher) view.
interface brancher_arbiter_if #(
  parameter int NUM_REQ = 2
);
  // requester side
  logic [NUM_REQ-1:0]    rx_req;
  logic [16*NUM_REQ-1:0] rx_req_branch;
  logic [4*NUM_REQ-1:0]  rx_req_check;
  logic [4*NUM_REQ-1:0]  rx_req_flags;
  logic [NUM_REQ-1:0]    tx_grant;
  logic [NUM_REQ-1:0]    tx_done;
  logic                  tx_error;
  logic [15:0]           tx_pc;

  // brancher side
  logic                  tx_br_enable;
  logic                  tx_br_write_flags;
  logic                  tx_br_write_branch;
  logic                  tx_br_strobe;
  logic [3:0]            tx_br_check_flags;
  logic [3:0]            tx_br_input_flags;
  logic [15:0]           tx_br_branch;
  logic [15:0]           rx_br_pc;
  logic                  rx_br_ready;

  modport master (
    input  rx_req, rx_req_branch, rx_req_check, rx_req_flags, rx_br_pc, rx_br_ready,
    output tx_grant, tx_done, tx_error, tx_pc,
    output tx_br_enable, tx_br_write_flags, tx_br_write_branch, tx_br_strobe,
    output tx_br_check_flags, tx_br_input_flags, tx_br_branch
  );

  modport slave (
    output rx_req, rx_req_branch, rx_req_check, rx_req_flags, rx_br_pc, rx_br_ready,
    input  tx_grant, tx_done, tx_error, tx_pc,
    input  tx_br_enable, tx_br_write_flags, tx_br_write_branch, tx_br_strobe,
    input  tx_br_check_flags, tx_br_input_flags, tx_br_branch
  );
endinterface

// File: rtl/brancher_arbiter.sv
// Shares one brancher between NUM_REQ requesters: arbitrate, sequence the handshake, return PC.
// Define BRANCHER_ARB_PRIORITY_EN for fixed lowest-index-wins priority (default: round-robin).
module brancher_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               aclk,
  input  logic               areset,
  brancher_arbiter_if.master bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_FLAGS  = 3'd1;
  localparam logic [2:0] S_WR_BRANCH = 3'd2;
  localparam logic [2:0] S_STROBE    = 3'd3;
  localparam logic [2:0] S_WAIT      = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [15:0]        branch_q, branch_d;
  logic [3:0]         check_q, check_d;
  logic [3:0]         flags_q, flags_d;

  logic [NUM_REQ-1:0] tx_grant_q, tx_grant_d;
  logic [NUM_REQ-1:0] tx_done_q, tx_done_d;
  logic               tx_error_q, tx_error_d;
  logic [15:0]        tx_pc_q, tx_pc_d;
  logic               br_enable_q, br_enable_d;
  logic               br_write_flags_q, br_write_flags_d;
  logic               br_write_branch_q, br_write_branch_d;
  logic               br_strobe_q, br_strobe_d;
  logic [3:0]         br_check_flags_q, br_check_flags_d;
  logic [3:0]         br_input_flags_q, br_input_flags_d;
  logic [15:0]        br_branch_q, br_branch_d;

`ifndef BRANCHER_ARB_PRIORITY_EN
  logic [IW-1:0]      rr_q, rr_d;
`endif

  logic               win_valid;
  logic [IW-1:0]      win_idx;
  logic [15:0]        win_branch;
  logic [3:0]         win_check;
  logic [3:0]         win_flags;
  logic               busy_d;

  // Winner selection and operand mux for the current request vector.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    win_valid  = 1'b0;
    win_idx    = '0;
    win_branch = '0;
    win_check  = '0;
    win_flags  = '0;
`ifdef BRANCHER_ARB_PRIORITY_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_valid && bus.rx_req[IW'(i)]) begin
        win_valid = 1'b1;
        win_idx   = IW'(i);
      end
    end
`else
    for (int i = 0; i < NUM_REQ; i++) begin
      logic [IW:0] idx_w;
      // rotate the search so it starts at the round-robin pointer
      idx_w = {1'b0, rr_q} + (IW+1)'(i);
      if (idx_w >= (IW+1)'(NUM_REQ)) idx_w = idx_w - (IW+1)'(NUM_REQ);
      if (!win_valid && bus.rx_req[idx_w[IW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = idx_w[IW-1:0];
      end
    end
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_branch = bus.rx_req_branch[16*i +: 16];
        win_check  = bus.rx_req_check[4*i +: 4];
        win_flags  = bus.rx_req_flags[4*i +: 4];
      end
    end
  end

  // Sequencer next state, then every output decoded from the next state so it lands in a flop.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    branch_d   = branch_q;
    check_d    = check_q;
    flags_d    = flags_q;
    tx_pc_d    = tx_pc_q;
    tx_error_d = 1'b0;
`ifndef BRANCHER_ARB_PRIORITY_EN
    rr_d       = rr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          state_d  = S_WR_FLAGS;
          owner_d  = win_idx;
          branch_d = win_branch;
          check_d  = win_check;
          flags_d  = win_flags;
        end
      end
      S_WR_FLAGS:  state_d = S_WR_BRANCH;
      S_WR_BRANCH: state_d = S_STROBE;
      S_STROBE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (bus.rx_br_ready) begin
          tx_pc_d = bus.rx_br_pc;
          state_d = S_DONE;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          // ready arriving on the last allowed cycle still wins over the abort
          if (cnt_q == CNT_LAST) begin
            tx_error_d = 1'b1;
            state_d    = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifndef BRANCHER_ARB_PRIORITY_EN
        rr_d = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_WR_FLAGS) || (state_d == S_WR_BRANCH) ||
             (state_d == S_STROBE)   || (state_d == S_WAIT);

    tx_grant_d = '0;
    if (busy_d) tx_grant_d[owner_d] = 1'b1;
    tx_done_d = '0;
    if (state_d == S_DONE) tx_done_d[owner_d] = 1'b1;

    br_enable_d       = busy_d;
    br_write_flags_d  = (state_d == S_WR_FLAGS);
    br_write_branch_d = (state_d == S_WR_BRANCH);
    br_strobe_d       = (state_d == S_STROBE);
    br_check_flags_d  = (state_d == S_WR_FLAGS)  ? check_d  : 4'h0;
    br_branch_d       = (state_d == S_WR_BRANCH) ? branch_d : 16'h0000;
    br_input_flags_d  = (state_d == S_STROBE)    ? flags_d  : 4'h0;
  end

  always_ff @(posedge aclk) begin
    // NOTE: there is no storage array here, so every flop including the capture registers is reset.
    if (areset) begin
      state_q           <= S_IDLE;
      owner_q           <= '0;
      cnt_q             <= '0;
      branch_q          <= '0;
      check_q           <= '0;
      flags_q           <= '0;
      tx_grant_q        <= '0;
      tx_done_q         <= '0;
      tx_error_q        <= 1'b0;
      tx_pc_q           <= '0;
      br_enable_q       <= 1'b0;
      br_write_flags_q  <= 1'b0;
      br_write_branch_q <= 1'b0;
      br_strobe_q       <= 1'b0;
      br_check_flags_q  <= '0;
      br_input_flags_q  <= '0;
      br_branch_q       <= '0;
`ifndef BRANCHER_ARB_PRIORITY_EN
      rr_q              <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so all flops update together from the pre-edge values.
      state_q           <= state_d;
      owner_q           <= owner_d;
      cnt_q             <= cnt_d;
      branch_q          <= branch_d;
      check_q           <= check_d;
      flags_q           <= flags_d;
      tx_grant_q        <= tx_grant_d;
      tx_done_q         <= tx_done_d;
      tx_error_q        <= tx_error_d;
      tx_pc_q           <= tx_pc_d;
      br_enable_q       <= br_enable_d;
      br_write_flags_q  <= br_write_flags_d;
      br_write_branch_q <= br_write_branch_d;
      br_strobe_q       <= br_strobe_d;
      br_check_flags_q  <= br_check_flags_d;
      br_input_flags_q  <= br_input_flags_d;
      br_branch_q       <= br_branch_d;
`ifndef BRANCHER_ARB_PRIORITY_EN
      rr_q              <= rr_d;
`endif
    end
  end

  assign bus.tx_grant           = tx_grant_q;
  assign bus.tx_done            = tx_done_q;
  assign bus.tx_error           = tx_error_q;
  assign bus.tx_pc              = tx_pc_q;
  assign bus.tx_br_enable       = br_enable_q;
  assign bus.tx_br_write_flags  = br_write_flags_q;
  assign bus.tx_br_write_branch = br_write_branch_q;
  assign bus.tx_br_strobe       = br_strobe_q;
  assign bus.tx_br_check_flags  = br_check_flags_q;
  assign bus.tx_br_input_flags  = br_input_flags_q;
  assign bus.tx_br_branch       = br_branch_q;

endmodule

// File: tb/tb_brancher_arbiter.sv
// Scoreboard bench for brancher_arbiter: expected operations are queued at stimulus time
// and checked cycle by cycle as the DUT walks the brancher handshake.
module tb_brancher_arbiter;

  localparam int NUM_REQ        = 2;
  localparam int TIMEOUT_CYCLES = 4;

  typedef struct {
    logic [NUM_REQ-1:0] grant;
    logic [15:0]        branch;
    logic [3:0]         check_f;
    logic [3:0]         flags;
    int                 ready_delay;
    logic [15:0]        resp_pc;
    logic [15:0]        exp_pc;
    logic               exp_err;
    int                 exp_wait;
  } exp_t;

  logic aclk;
  logic areset;

  brancher_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  brancher_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  exp_t        exp_q[$];
  int          m_rr    = 0;
  logic [15:0] m_pc    = '0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #100000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {bus.tx_br_enable, bus.tx_br_write_flags, bus.tx_br_write_branch, bus.tx_br_strobe};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(bus.tx_grant), 0);
    check({tag, "_done"},  32'(bus.tx_done), 0);
    check({tag, "_error"}, 32'(bus.tx_error), 0);
    check({tag, "_pc"},    32'(bus.tx_pc), 0);
    check({tag, "_strb"},  32'(strobes()), 0);
    check({tag, "_bus"},   {bus.tx_br_branch, 8'h00, bus.tx_br_check_flags, bus.tx_br_input_flags}, 0);
  endtask

  task automatic set_ops(input int i, input logic [15:0] br, input logic [3:0] ck, input logic [3:0] fl);
    bus.rx_req_branch[16*i +: 16] = br;
    bus.rx_req_check[4*i +: 4]    = ck;
    bus.rx_req_flags[4*i +: 4]    = fl;
  endtask

  // Predict the next grant from the driven request vector and queue the expected outcome.
  task automatic expect_op(input int ready_delay, input logic [15:0] resp_pc);
    exp_t e;
    int   w;
    w = -1;
`ifdef BRANCHER_ARB_PRIORITY_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) if (bus.rx_req[i]) w = i;
`else
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = (m_rr + i) % NUM_REQ;
      if (w < 0 && bus.rx_req[j]) w = j;
    end
`endif
    if (w < 0) w = 0;
    e.grant       = NUM_REQ'(1) << w;
    e.branch      = 16'(bus.rx_req_branch >> (16 * w));
    e.check_f     = 4'(bus.rx_req_check >> (4 * w));
    e.flags       = 4'(bus.rx_req_flags >> (4 * w));
    e.ready_delay = ready_delay;
    e.resp_pc     = resp_pc;
    if (ready_delay >= 0 && ready_delay < TIMEOUT_CYCLES) begin
      e.exp_pc   = resp_pc;
      e.exp_err  = 1'b0;
      e.exp_wait = ready_delay + 1;
    end else begin
      e.exp_pc   = m_pc;
      e.exp_err  = 1'b1;
      e.exp_wait = TIMEOUT_CYCLES;
    end
    m_pc = e.exp_pc;
    m_rr = (w + 1) % NUM_REQ;
    exp_q.push_back(e);
  endtask

  // Called at an IDLE negedge with requests driven; returns at the IDLE negedge after DONE.
  task automatic run_op(input bit mutate, input bit early_ready);
    exp_t e;
    int   waits;
    bit   seen;
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    if (early_ready) begin
      bus.rx_br_ready = 1'b1;
      bus.rx_br_pc    = ~e.resp_pc;
    end

    @(negedge aclk);
    check("wf_grant", 32'(bus.tx_grant), 32'(e.grant));
    check("wf_strb",  32'(strobes()), 32'hC);
    check("wf_check", 32'(bus.tx_br_check_flags), 32'(e.check_f));
    if (mutate) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (e.grant[i]) bus.rx_req_branch[16*i +: 16] = 16'hFFFF;
    end

    @(negedge aclk);
    bus.rx_br_ready = 1'b0;
    check("wb_strb",   32'(strobes()), 32'hA);
    check("wb_branch", 32'(bus.tx_br_branch), 32'(e.branch));
    if (mutate) bus.rx_req = '0;

    @(negedge aclk);
    check("st_strb",  32'(strobes()), 32'h9);
    check("st_flags", 32'(bus.tx_br_input_flags), 32'(e.flags));
    check("st_grant", 32'(bus.tx_grant), 32'(e.grant));

    @(negedge aclk);
    waits = 0;
    seen  = 1'b0;
    for (int k = 0; k < TIMEOUT_CYCLES + 2 && !seen; k++) begin
      if (bus.tx_done != '0) begin
        seen = 1'b1;
      end else begin
        waits++;
        check("wait_strb", 32'(strobes()), 32'h8);
        bus.rx_br_ready = (k == e.ready_delay);
        bus.rx_br_pc    = (k == e.ready_delay) ? e.resp_pc : ~e.resp_pc;
        @(negedge aclk);
      end
    end
    bus.rx_br_ready = 1'b0;
    check("done_seen",   32'(seen), 1);
    check("wait_cycles", 32'(waits), 32'(e.exp_wait));
    check("done_mask",   32'(bus.tx_done), 32'(e.grant));
    check("done_error",  32'(bus.tx_error), 32'(e.exp_err));
    check("done_pc",     32'(bus.tx_pc), 32'(e.exp_pc));
    check("done_idle",   {bus.tx_grant, strobes()}, 0);

    @(negedge aclk);
    check("idle_outs", {bus.tx_done, bus.tx_error, bus.tx_grant, strobes()}, 0);
    check("idle_pc",   32'(bus.tx_pc), 32'(e.exp_pc));
  endtask

  initial begin
    int done_cnt;
    areset            = 1'b1;
    bus.rx_req        = '0;
    bus.rx_req_branch = '0;
    bus.rx_req_check  = '0;
    bus.rx_req_flags  = '0;
    bus.rx_br_pc      = '0;
    bus.rx_br_ready   = 1'b0;
    repeat (3) @(negedge aclk);
    check_all_zero("reset");
    areset = 1'b0;
    @(negedge aclk);

    // simultaneous requests held for three operations
    set_ops(0, 16'h1111, 4'h5, 4'h6);
    set_ops(1, 16'h2222, 4'hA, 4'h9);
    bus.rx_req = 2'b11;
    expect_op(0, 16'h0100);
    expect_op(1, 16'h0200);
    expect_op(2, 16'h0300);
    repeat (3) run_op(1'b0, 1'b0);
    bus.rx_req = '0;

    // single request, ready on the first WAIT cycle
    set_ops(0, 16'h1234, 4'h3, 4'h1);
    bus.rx_req = 2'b01;
    expect_op(0, 16'h5678);
    run_op(1'b0, 1'b0);
    bus.rx_req = '0;

    // brancher never answers
    set_ops(1, 16'hBEEF, 4'hC, 4'h3);
    bus.rx_req = 2'b10;
    expect_op(-1, 16'hDEAD);
    run_op(1'b0, 1'b0);
    bus.rx_req = '0;

    // ready asserted early must be ignored
    set_ops(0, 16'h0F0F, 4'h7, 4'h8);
    bus.rx_req = 2'b01;
    expect_op(0, 16'h4242);
    run_op(1'b0, 1'b1);
    bus.rx_req = '0;

    // operands change and request drops after grant
    set_ops(0, 16'hA55A, 4'h2, 4'h4);
    bus.rx_req = 2'b01;
    expect_op(1, 16'h9999);
    run_op(1'b1, 1'b0);
    bus.rx_req = '0;

    // reset in WAIT aborts silently and restarts arbitration from requester 0
    set_ops(0, 16'h3333, 4'h1, 4'h2);
    bus.rx_req = 2'b01;
    repeat (4) @(negedge aclk);
    check("abort_wait", {bus.tx_grant, strobes()}, {2'b01, 4'h8});
    areset     = 1'b1;
    bus.rx_req = '0;
    @(negedge aclk);
    check_all_zero("abort");
    areset   = 1'b0;
    m_rr     = 0;
    m_pc     = '0;
    done_cnt = 0;
    repeat (3) begin
      @(negedge aclk);
      if (bus.tx_done != '0) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 0);
    bus.rx_req = 2'b11;
    expect_op(0, 16'h7777);
    run_op(1'b0, 1'b0);
    bus.rx_req = '0;

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
